// File: rtl/lamp_sequence_checker.sv
// Receive-side monitor for the one-hot traffic-lamp bus: decodes the colour,
// checks red->yellow->green->red order and flags code/order/stuck faults.
//
// Ports:
//   clock, reset     : system clock, synchronous active-high reset
//   light[0:2]       : lamp bus, red=100 yellow=010 green=001 (bit 0 = red)
//   sample_en        : sample light this cycle
//   phase            : decoded colour 0=red 1=yellow 2=green 3=unknown
//   locked           : tracking a legal sequence
//   code_err         : pulse, sampled code not one-hot
//   seq_err          : pulse, valid colour out of order
//   stuck_err        : pulse, colour held beyond MAX_DWELL samples
//   cycle_done       : pulse, full red->yellow->green->red observed
//   err_count        : saturating total of error pulses
//   cycle_count      : saturating count of cycle_done pulses, present only
//                      when LAMP_CHECKER_STATS_EN is defined
module lamp_sequence_checker #(
   parameter int MAX_DWELL = 8,
   parameter int CNT_W     = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [0:2]       light,
   input  logic             sample_en,
   output logic [1:0]       phase,
   output logic             locked,
   output logic             code_err,
   output logic             seq_err,
   output logic             stuck_err,
   output logic             cycle_done,
   output logic [CNT_W-1:0] err_count
`ifdef LAMP_CHECKER_STATS_EN
   ,
   output logic [CNT_W-1:0] cycle_count
`endif
);

   localparam int DW = $clog2(MAX_DWELL + 1);
   localparam logic [DW-1:0] DMAX = DW'(MAX_DWELL);

   typedef enum logic {UNSYNC, LOCK} state_t;

   state_t           state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [1:0]       trans_q, trans_d;
   logic             code_q, code_d;
   logic             seq_q, seq_d;
   logic             stuck_q, stuck_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] errc_q, errc_d;

   logic             valid;
   logic [1:0]       col;
   logic [1:0]       nxt;

   always_comb begin
      valid = 1'b1;
      col   = 2'd3;
      case (light)
         3'b100:  col = 2'd0;
         3'b010:  col = 2'd1;
         3'b001:  col = 2'd2;
         default: valid = 1'b0;
      endcase
   end

   // Expected successor of the current colour.
   always_comb begin
      case (phase_q)
         2'd0:    nxt = 2'd1;
         2'd1:    nxt = 2'd2;
         default: nxt = 2'd0;
      endcase
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= UNSYNC;
         phase_q <= 2'd3;
         dwell_q <= '0;
         trans_q <= '0;
         code_q  <= 1'b0;
         seq_q   <= 1'b0;
         stuck_q <= 1'b0;
         done_q  <= 1'b0;
         errc_q  <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         dwell_q <= dwell_d;
         trans_q <= trans_d;
         code_q  <= code_d;
         seq_q   <= seq_d;
         stuck_q <= stuck_d;
         done_q  <= done_d;
         errc_q  <= errc_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (sample_en) begin
         if (!valid) begin
            state_d = UNSYNC;
         end else if (state_q == UNSYNC) begin
            state_d = LOCK;
         end else if (col == phase_q && dwell_q >= DMAX) begin
            state_d = UNSYNC;
         end
      end
   end

   // Output / datapath logic
   always_comb begin
      phase_d = phase_q;
      dwell_d = dwell_q;
      trans_d = trans_q;
      code_d  = 1'b0;
      seq_d   = 1'b0;
      stuck_d = 1'b0;
      done_d  = 1'b0;
      if (sample_en) begin
         if (!valid) begin
            code_d  = 1'b1;
            phase_d = 2'd3;
            dwell_d = '0;
            trans_d = '0;
         end else if (state_q == UNSYNC) begin
            phase_d = col;
            dwell_d = DW'(1);
            trans_d = '0;
         end else if (col == phase_q) begin
            if (dwell_q < DMAX) begin
               dwell_d = dwell_q + DW'(1);
            end else begin
               stuck_d = 1'b1;
               phase_d = 2'd3;
               dwell_d = '0;
               trans_d = '0;
            end
         end else if (col == nxt) begin
            phase_d = col;
            dwell_d = DW'(1);
            if (col == 2'd0) begin
               // Wrap to red closes a cycle only after two in-order steps.
               done_d  = (trans_q == 2'd2);
               trans_d = '0;
            end else begin
               trans_d = trans_q + 2'd1;
            end
         end else begin
            seq_d   = 1'b1;
            phase_d = col;
            dwell_d = DW'(1);
            trans_d = '0;
         end
      end
      errc_d = errc_q;
      if ((code_d | seq_d | stuck_d) && errc_q != '1) begin
         errc_d = errc_q + CNT_W'(1);
      end
   end

   assign phase      = phase_q;
   assign locked     = (state_q == LOCK);
   assign code_err   = code_q;
   assign seq_err    = seq_q;
   assign stuck_err  = stuck_q;
   assign cycle_done = done_q;
   assign err_count  = errc_q;

`ifdef LAMP_CHECKER_STATS_EN
   logic [CNT_W-1:0] cyc_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         cyc_q <= '0;
      end else if (done_q && cyc_q != '1) begin
         cyc_q <= cyc_q + CNT_W'(1);
      end
   end

   assign cycle_count = cyc_q;
`endif

endmodule
